// File: rtl/cu_datapath.sv
// Datapath of the 8-bit accumulator processor: PC, IR, accumulator A, 32x8 unified
// memory, add/sub unit and steering muxes, plus a program-load port for memory fill.
module cu_datapath #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = ADDR_W + 3,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IRload,
  input  logic              JMPmux,
  input  logic              PCload,
  input  logic              Meminst,
  input  logic              MemWr,
  input  logic [1:0]        Asel,
  input  logic              Aload,
  input  logic              Sub,
  input  logic [DATA_W-1:0] Input,
  input  logic              ProgWr,
  input  logic [ADDR_W-1:0] ProgAddr,
  input  logic [DATA_W-1:0] ProgData,
  output logic [2:0]        IR,
  output logic              Aeq0,
  output logic              Apos,
  output logic [DATA_W-1:0] Output,
  output logic [ADDR_W-1:0] PCout
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] a;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] a_next;
  logic [ADDR_W-1:0] pc_next;

  // Combinational address steering and asynchronous memory read
  always_comb begin
    addr  = Meminst ? pc : ir_reg[ADDR_W-1:0];
    rdata = mem[addr];
    alu   = Sub ? (a - rdata) : (a + rdata);
  end

  // Accumulator source and PC source selection
  always_comb begin
    a_next  = '0;
    pc_next = JMPmux ? ir_reg[ADDR_W-1:0] : (pc + ADDR_W'(1));
    case (Asel)
      2'b00:   a_next = alu;
      2'b01:   a_next = Input;
      2'b10:   a_next = rdata;
      default: a_next = '0;
    endcase
  end

  // Architectural registers; every load samples pre-edge values
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc     <= '0;
      ir_reg <= '0;
      a      <= '0;
    end else begin
      if (IRload) ir_reg <= rdata;
      if (PCload) pc     <= pc_next;
      if (Aload)  a      <= a_next;
    end
  end

  // Memory is never cleared; a datapath store takes priority over program load
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (MemWr)       mem[addr]     <= a;
      else if (ProgWr) mem[ProgAddr] <= ProgData;
    end
  end

  always_comb begin
    IR     = ir_reg[DATA_W-1:DATA_W-3];
    Aeq0   = (a == '0);
    Apos   = ~a[DATA_W-1] & (a != '0);
    Output = a;
    PCout  = pc;
  end

endmodule

// File: tb/tb_cu_datapath.sv
// Directed test-plan steps followed by random control words, checked against an
// integer-arithmetic model of the processor state.
module tb_cu_datapath;

  logic       Clock;
  logic       Reset;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, ProgWr;
  logic [1:0] Asel;
  logic [7:0] Input, ProgData;
  logic [4:0] ProgAddr;
  logic [2:0] IR;
  logic       Aeq0, Apos;
  logic [7:0] Output;
  logic [4:0] PCout;

  int n_tests = 0;
  int n_fail  = 0;

  int m_mem [32];
  int m_pc, m_ir, m_a;

  cu_datapath dut (
    .Clock(Clock), .Reset(Reset), .IRload(IRload), .JMPmux(JMPmux),
    .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel),
    .Aload(Aload), .Sub(Sub), .Input(Input), .ProgWr(ProgWr),
    .ProgAddr(ProgAddr), .ProgData(ProgData), .IR(IR), .Aeq0(Aeq0),
    .Apos(Apos), .Output(Output), .PCout(PCout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic idle();
    Reset = 1'b1; IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0;
    Asel = 2'b00; Aload = 0; Sub = 0; Input = 8'h00; ProgWr = 0;
    ProgAddr = 5'd0; ProgData = 8'h00;
  endtask

  // Advance the model one cycle from the current inputs, clock the DUT, compare
  task automatic tick(input string tag);
    int addr, rd, na, npc, nir;
    addr = Meminst ? m_pc : (m_ir % 32);
    rd   = m_mem[addr];
    case (Asel)
      2'd0:    na = Sub ? (m_a - rd + 256) % 256 : (m_a + rd) % 256;
      2'd1:    na = int'(Input);
      2'd2:    na = rd;
      default: na = 0;
    endcase
    npc = JMPmux ? (m_ir % 32) : (m_pc + 1) % 32;
    nir = rd;
    if (!Reset) begin
      m_pc = 0; m_ir = 0; m_a = 0;
    end else begin
      if (MemWr)       m_mem[addr] = m_a;
      else if (ProgWr) m_mem[int'(ProgAddr)] = int'(ProgData);
      if (IRload) m_ir = nir;
      if (PCload) m_pc = npc;
      if (Aload)  m_a  = na;
    end
    @(posedge Clock);
    #1;
    chk(tag, "IR",     32'(IR),     32'(m_ir / 32));
    chk(tag, "Aeq0",   32'(Aeq0),   32'(m_a == 0));
    chk(tag, "Apos",   32'(Apos),   32'(m_a > 0 && m_a < 128));
    chk(tag, "Output", 32'(Output), 32'(m_a));
    chk(tag, "PCout",  32'(PCout),  32'(m_pc));
  endtask

  task automatic prog(input int ad, input int d);
    idle(); ProgWr = 1; ProgAddr = 5'(ad); ProgData = 8'(d);
    tick("prog");
  endtask

  initial begin
    m_pc = 0; m_ir = 0; m_a = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    idle();
    @(negedge Clock);
    Reset = 0; tick("init_rst"); tick("init_rst");

    for (int i = 0; i < 32; i++) prog(i, int'($urandom_range(0, 255)));

    // Reset with every control asserted must not disturb memory
    Reset = 0; IRload = 1; JMPmux = 1; PCload = 1; Meminst = 1; MemWr = 1;
    Asel = 2'b01; Aload = 1; Sub = 1; Input = 8'h5A; ProgWr = 1;
    ProgAddr = 5'd9; ProgData = 8'hC3;
    tick("reset_all"); tick("reset_all");
    for (int i = 0; i < 32; i++) begin
      idle(); Asel = 2'b10; Aload = 1; Meminst = 1; PCload = 1; tick("mem_kept");
    end

    // Fetch from address 0
    prog(0, 8'h43);
    idle(); Meminst = 1; IRload = 1; PCload = 1; tick("fetch");

    // Arithmetic wrap: 0x80 + 0x90, then 0x10 - 0x10
    prog(3, 8'h90);
    idle(); Input = 8'h80; Asel = 2'b01; Aload = 1; tick("load_a80");
    idle(); Asel = 2'b00; Aload = 1; tick("add_wrap");
    prog(3, 8'h10);
    idle(); Asel = 2'b00; Sub = 1; Aload = 1; tick("sub_zero");

    // IN then STORE to address 7 and read it back
    prog(1, 8'h07);
    idle(); Meminst = 1; IRload = 1; PCload = 1; tick("fetch_07");
    idle(); Input = 8'hFE; Asel = 2'b01; Aload = 1; tick("in_fe");
    idle(); MemWr = 1; tick("store");
    idle(); Asel = 2'b11; Aload = 1; tick("clear_a");
    idle(); Asel = 2'b10; Aload = 1; tick("read_back");

    // Jump to 5, then jump to 31 and wrap on increment
    prog(2, 8'h05);
    idle(); Meminst = 1; IRload = 1; PCload = 1; tick("fetch_05");
    idle(); JMPmux = 1; PCload = 1; tick("jump5");
    prog(5, 8'h1F);
    idle(); Meminst = 1; IRload = 1; PCload = 1; tick("fetch_1f");
    idle(); JMPmux = 1; PCload = 1; tick("jump31");
    idle(); PCload = 1; tick("pc_wrap");

    // MemWr and ProgWr collide on address 7
    prog(0, 8'h07);
    idle(); Meminst = 1; IRload = 1; tick("fetch_07b");
    idle(); Input = 8'h11; Asel = 2'b01; Aload = 1; tick("in_11");
    idle(); MemWr = 1; ProgWr = 1; ProgAddr = 5'd7; ProgData = 8'h22; tick("collide");
    idle(); Asel = 2'b11; Aload = 1; tick("clear_a2");
    idle(); Asel = 2'b10; Aload = 1; tick("collide_rd");

    // Reset wins over a simultaneous accumulator load
    idle(); Reset = 0; Input = 8'h55; Asel = 2'b01; Aload = 1; tick("mid_reset");

    // Random control words
    for (int i = 0; i < 400; i++) begin
      Reset    = ($urandom_range(0, 29) != 0);
      IRload   = 1'($urandom); JMPmux = 1'($urandom); PCload = 1'($urandom);
      Meminst  = 1'($urandom); MemWr  = ($urandom_range(0, 3) == 0);
      Asel     = 2'($urandom); Aload  = 1'($urandom); Sub    = 1'($urandom);
      Input    = 8'($urandom); ProgWr = 1'($urandom);
      ProgAddr = 5'($urandom); ProgData = 8'($urandom);
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
